// File: rtl/wb_stream_tx_pkg.sv
// Register map, field positions and helpers shared by the Wishbone-to-stream transmitter.
package wb_stream_tx_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int STATUS_EMPTY     = 0;
    localparam int STATUS_FULL      = 1;
    localparam int STATUS_LEVEL_LSB = 8;

    localparam int CTRL_ENABLE     = 0;
    localparam int CTRL_FLUSH      = 1;
    localparam int CTRL_THRESH_LSB = 8;

    typedef struct packed {
        logic [7:0] thresh;
        logic       enable;
    } ctrl_t;

    function automatic logic [15:0] status_word(logic empty, logic full, logic [7:0] level);
        logic [15:0] w;
        w = '0;
        w[STATUS_EMPTY] = empty;
        w[STATUS_FULL] = full;
        w[STATUS_LEVEL_LSB +: 8] = level;
        return w;
    endfunction

    // Flush is a pulse, never stored, so it always reads back as 0.
    function automatic logic [15:0] ctrl_word(ctrl_t c);
        logic [15:0] w;
        w = '0;
        w[CTRL_ENABLE] = c.enable;
        w[CTRL_THRESH_LSB +: 8] = c.thresh;
        return w;
    endfunction

endpackage

// File: rtl/wb_if.sv
// Pipelined Wishbone bus bundle with responder and initiator views.
interface wb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH-1:0]   dat_m;
    logic [DATA_WIDTH-1:0]   dat_s;
    logic [DATA_WIDTH/8-1:0] sel;
    logic                    we;
    logic                    stb;
    logic                    cyc;
    logic                    ack;
    logic                    err;
    logic                    stall;

    modport slave (
        input  adr, dat_m, sel, we, stb, cyc,
        output dat_s, ack, err, stall
    );

    modport master (
        output adr, dat_m, sel, we, stb, cyc,
        input  dat_s, ack, err, stall
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-around pointers, explicit level and synchronous flush.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] level,
    output logic                   empty,
    output logic                   full
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PtrOne = 1;
    localparam logic [PW:0]   LvlOne = 1;
    localparam logic [PW:0]   LvlMax = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      level_q;
    logic             do_push, do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LvlMax);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr_q];
    assign level   = level_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Flush takes priority over any concurrent pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LvlOne;
                2'b01:   level_q <= level_q - LvlOne;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/wb_stream_tx.sv
// Wishbone-programmed transmit FIFO: bus writes to DATA are streamed out on a valid/ready port.
module wb_stream_tx
    import wb_stream_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    wb_if.slave                   wbs,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  irq
);
    localparam int LevelW = $clog2(FIFO_DEPTH) + 1;
    localparam int CmpW   = (LevelW > 8) ? LevelW : 8;

    logic [1:0]            reg_sel;
    logic                  req, stall, accept, wr, rd;
    logic                  push, pop, flush, ctrl_wr;
    logic                  fifo_empty, fifo_full;
    logic [LevelW-1:0]     fifo_level;
    logic [DATA_WIDTH-1:0] rdata;
    ctrl_t                 ctrl_q, ctrl_wdata;
    logic                  ack_q;
    logic [DATA_WIDTH-1:0] dat_s_q;
    logic                  unused_bits;

    assign reg_sel = wbs.adr[3:2];
    assign req     = wbs.cyc && wbs.stb;
    // Stall depends only on registered FIFO state, never on out_ready.
    assign stall   = req && wbs.we && (reg_sel == REG_DATA) && fifo_full;
    assign accept  = req && !stall;
    assign wr      = accept && wbs.we;
    assign rd      = accept && !wbs.we;

    assign push    = wr && (reg_sel == REG_DATA);
    assign ctrl_wr = wr && (reg_sel == REG_CTRL);
    assign flush   = ctrl_wr && wbs.dat_m[CTRL_FLUSH];
    assign pop     = out_valid && out_ready;

    assign ctrl_wdata.enable = wbs.dat_m[CTRL_ENABLE];
    assign ctrl_wdata.thresh = wbs.dat_m[CTRL_THRESH_LSB +: 8];

    sync_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data(wbs.dat_m),
        .pop      (pop),
        .flush    (flush),
        .head     (out_data),
        .level    (fifo_level),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_STATUS: rdata[15:0] = status_word(fifo_empty, fifo_full, 8'(fifo_level));
            REG_CTRL:   rdata[15:0] = ctrl_word(ctrl_q);
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q   <= 1'b0;
            dat_s_q <= '0;
            ctrl_q  <= '0;
        end else begin
            ack_q   <= accept;
            dat_s_q <= rd ? rdata : '0;
            if (ctrl_wr) begin
                ctrl_q <= ctrl_wdata;
            end
        end
    end

    assign wbs.ack   = ack_q;
    assign wbs.dat_s = dat_s_q;
    assign wbs.err   = 1'b0;
    assign wbs.stall = stall;

    assign out_valid = !fifo_empty && ctrl_q.enable;
    assign irq       = ctrl_q.enable && (CmpW'(fifo_level) <= CmpW'(ctrl_q.thresh));

    assign unused_bits = ^{wbs.sel, wbs.adr[ADDR_WIDTH-1:4], wbs.adr[1:0]};

endmodule

// File: tb/tb_wb_stream_tx.sv
// Self-checking bench for wb_stream_tx: directed table, corner sequences and a randomized run
// checked against a queue-based reference model.
module tb_wb_stream_tx;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int DEPTH = 16;
    localparam logic [1:0] R_DATA = 2'd0;
    localparam logic [1:0] R_STAT = 2'd1;
    localparam logic [1:0] R_CTRL = 2'd2;
    localparam logic [1:0] R_RSVD = 2'd3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          irq;

    wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wb ();

    wb_stream_tx #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wbs      (wb),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: the FIFO is a plain queue; registers are plain variables.
    logic [31:0] q[$];
    bit          m_en;
    bit [7:0]    m_thr;
    bit          m_ack;
    bit [31:0]   m_dat;

    // Values sampled during the most recent step.
    logic        s_ack, s_stall, s_valid, s_irq;
    logic [31:0] s_dat, s_data;

    typedef struct packed {
        logic        we;
        logic [1:0]  r;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_en = 0;
        m_thr = 0;
        m_ack = 0;
        m_dat = 0;
    endtask

    task automatic set_req(input bit cyc, input bit stb, input bit we, input logic [1:0] r,
                           input logic [31:0] d);
        logic [31:0] a;
        a = $urandom();
        a[3:2] = r;
        wb.adr = a;
        wb.cyc = cyc;
        wb.stb = stb;
        wb.we = we;
        wb.dat_m = d;
        wb.sel = 4'($urandom());
    endtask

    task automatic set_idle();
        set_req(0, 0, 0, 2'd0, 32'h0);
    endtask

    // Called just after a falling edge with inputs applied; checks, advances the model, and
    // returns just after the next falling edge.
    task automatic step();
        bit          exp_stall, exp_valid, acc, pop;
        logic [1:0]  r;
        logic [31:0] rdv;
        #1;
        s_ack = wb.ack;
        s_dat = wb.dat_s;
        s_stall = wb.stall;
        s_valid = out_valid;
        s_data = out_data;
        s_irq = irq;
        r = wb.adr[3:2];
        exp_stall = wb.cyc && wb.stb && wb.we && (r == R_DATA) && (q.size() == DEPTH);
        exp_valid = m_en && (q.size() != 0);
        check("ack", 32'(s_ack), 32'(m_ack));
        check("dat_s", s_dat, m_dat);
        check("err", 32'(wb.err), 32'h0);
        check("stall", 32'(s_stall), 32'(exp_stall));
        check("out_valid", 32'(s_valid), 32'(exp_valid));
        if (exp_valid) check("out_data", s_data, q[0]);
        check("irq", 32'(s_irq), 32'(m_en && (q.size() <= int'(m_thr))));

        acc = wb.cyc && wb.stb && !exp_stall;
        pop = exp_valid && out_ready;
        rdv = 0;
        if (acc && !wb.we) begin
            if (r == R_STAT)
                rdv = (32'(q.size()) << 8) | (32'(q.size() == DEPTH) << 1) | 32'(q.size() == 0);
            else if (r == R_CTRL)
                rdv = (32'(m_thr) << 8) | 32'(m_en);
        end
        if (acc && wb.we && r == R_CTRL) begin
            if (wb.dat_m[1]) q.delete();
            else if (pop) void'(q.pop_front());
            m_en = wb.dat_m[0];
            m_thr = wb.dat_m[15:8];
        end else begin
            if (pop) void'(q.pop_front());
            if (acc && wb.we && r == R_DATA) q.push_back(wb.dat_m);
        end
        m_ack = acc;
        m_dat = rdv;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Single request followed by an idle cycle; s_ack/s_dat then hold the response.
    task automatic xact(input bit we, input logic [1:0] r, input logic [31:0] d);
        set_req(1, 1, we, r, d);
        step();
        set_idle();
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int acks;
        bit stall_seen;
        set_idle();
        model_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_ack", 32'(wb.ack), 32'h0);
        check("rst_dat_s", wb.dat_s, 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Register access table, block disabled, consumer idle.
        tbl[0] = '{we: 1'b0, r: R_STAT, d: 32'h0, exp: 32'h0000_0001};
        tbl[1] = '{we: 1'b0, r: R_CTRL, d: 32'h0, exp: 32'h0000_0000};
        tbl[2] = '{we: 1'b0, r: R_DATA, d: 32'h0, exp: 32'h0000_0000};
        tbl[3] = '{we: 1'b1, r: R_RSVD, d: 32'hFFFF_FFFF, exp: 32'h0000_0000};
        tbl[4] = '{we: 1'b0, r: R_RSVD, d: 32'h0, exp: 32'h0000_0000};
        tbl[5] = '{we: 1'b0, r: R_STAT, d: 32'h0, exp: 32'h0000_0001};
        tbl[6] = '{we: 1'b1, r: R_CTRL, d: 32'hFFFF_0500, exp: 32'h0000_0000};
        tbl[7] = '{we: 1'b0, r: R_CTRL, d: 32'h0, exp: 32'h0000_0500};
        tbl[8] = '{we: 1'b1, r: R_CTRL, d: 32'h0000_0002, exp: 32'h0000_0000};
        tbl[9] = '{we: 1'b0, r: R_CTRL, d: 32'h0, exp: 32'h0000_0000};
        for (int i = 0; i < 10; i++) begin
            xact(tbl[i].we, tbl[i].r, tbl[i].d);
            check($sformatf("vec%0d_ack", i), 32'(s_ack), 32'h1);
            check($sformatf("vec%0d_dat_s", i), s_dat, tbl[i].exp);
        end

        // 16 back-to-back DATA writes while disabled.
        acks = 0;
        stall_seen = 0;
        for (int i = 0; i < 16; i++) begin
            set_req(1, 1, 1, R_DATA, 32'h100 + 32'(i));
            step();
            acks += int'(s_ack);
            stall_seen |= s_stall;
        end
        set_idle();
        step();
        acks += int'(s_ack);
        check("b2b_acks", 32'(acks), 32'd16);
        check("b2b_no_stall", 32'(stall_seen), 32'h0);
        xact(0, R_STAT, 0);
        check("full_status", s_dat, 32'h0000_1002);
        set_req(1, 1, 1, R_DATA, 32'h110);
        for (int i = 0; i < 3; i++) begin
            step();
            check("write17_stall", 32'(s_stall), 32'h1);
        end
        set_idle();
        step();
        check("write17_dropped_noack", 32'(s_ack), 32'h0);

        // Enable and drain in order.
        xact(1, R_CTRL, 32'h1);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            check("drain_valid", 32'(s_valid), 32'h1);
            check("drain_data", s_data, 32'h100 + 32'(i));
        end
        step();
        check("drain_done_valid", 32'(s_valid), 32'h0);
        out_ready = 1'b0;

        // Refill, then a held write stalls until one pop frees a slot.
        for (int i = 0; i < 16; i++) begin
            set_req(1, 1, 1, R_DATA, 32'h200 + 32'(i));
            step();
        end
        set_req(1, 1, 1, R_DATA, 32'h2AA);
        step();
        check("held_stall", 32'(s_stall), 32'h1);
        out_ready = 1'b1;
        step();
        check("held_stall_during_pop", 32'(s_stall), 32'h1);
        out_ready = 1'b0;
        step();
        check("stall_released", 32'(s_stall), 32'h0);
        set_idle();
        step();
        check("held_write_ack", 32'(s_ack), 32'h1);

        // Flush, three entries, then a write with the consumer holding off.
        xact(1, R_CTRL, 32'h3);
        for (int i = 0; i < 3; i++) begin
            set_req(1, 1, 1, R_DATA, 32'hA0 + 32'(i));
            step();
        end
        set_req(1, 1, 1, R_DATA, 32'hA3);
        step();
        set_idle();
        step();
        check("hold_out_data", s_data, 32'hA0);
        xact(0, R_STAT, 0);
        check("level4_status", s_dat, 32'h0000_0400);
        check("hold_out_data_after", s_data, 32'hA0);

        // Level 10, then flush+enable+thresh write concurrent with a pop.
        for (int i = 4; i < 10; i++) begin
            set_req(1, 1, 1, R_DATA, 32'hA0 + 32'(i));
            step();
        end
        set_req(1, 1, 1, R_CTRL, 32'h0000_0403);
        out_ready = 1'b1;
        step();
        check("flush_pop_valid_before", 32'(s_valid), 32'h1);
        out_ready = 1'b0;
        set_idle();
        step();
        check("flush_valid", 32'(s_valid), 32'h0);
        check("flush_irq", 32'(s_irq), 32'h1);
        xact(0, R_STAT, 0);
        check("flush_status", s_dat, 32'h0000_0001);
        xact(0, R_CTRL, 0);
        check("flush_ctrl", s_dat, 32'h0000_0400 | 32'h1);

        // Reset while a request is in flight.
        set_req(1, 1, 1, R_DATA, 32'hBEEF);
        @(posedge clk);
        #1;
        set_idle();
        rst_n = 1'b0;
        #1;
        check("midrst_ack", 32'(wb.ack), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step();
        check("post_rst_noack", 32'(s_ack), 32'h0);
        xact(0, R_STAT, 0);
        check("post_rst_status", s_dat, 32'h0000_0001);
        xact(0, R_CTRL, 0);
        check("post_rst_ctrl", s_dat, 32'h0);

        // Randomized traffic against the model.
        xact(1, R_CTRL, 32'h0000_0801);
        for (int i = 0; i < 800; i++) begin
            int unsigned k;
            logic [31:0] d;
            logic [1:0] r;
            bit we;
            k = $urandom_range(0, 9);
            r = (k <= 5) ? R_DATA : (k == 6) ? R_STAT : (k == 7) ? R_CTRL : (k == 8) ? R_RSVD
                                                                        : R_DATA;
            we = (k == 9) ? 1'b0 : 1'($urandom());
            if (k <= 5) we = 1'b1;
            d = $urandom();
            if (r == R_CTRL && we) begin
                d = (32'($urandom_range(0, 17)) << 8) | 32'($urandom_range(0, 9) != 0);
                if ($urandom_range(0, 7) == 0) d = d | 32'h2;
            end
            set_req($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8, we, r, d);
            out_ready = ($urandom_range(0, 9) < 4);
            step();
        end
        set_idle();
        out_ready = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
